// File: rtl/conj_delay_demod_if.sv
// AXI-Stream IQ channel used for both the sample input and the product output.
// tdata carries {imag, real}; tstrb has one bit per tdata byte.
interface conj_delay_demod_if #(
  parameter int W = 32
);
  logic         tvalid;
  logic         tready;
  logic [W-1:0] tdata;
  logic         tlast;
  logic [W/8-1:0] tstrb;

  modport master (output tvalid, tdata, tlast, tstrb, input tready);
  modport slave  (input tvalid, tdata, tlast, tstrb, output tready);
endinterface

// File: rtl/conj_delay_demod.sv
// Lagged conjugate-multiply discriminator: y[n] = x[n] * conj(x[n-LAG]) on an IQ stream,
// with round/shift/saturate to OUT_W, optional history flush on tlast, and runtime bypass.
module conj_delay_demod #(
  parameter int DATA_W         = 16,
  parameter int OUT_W          = 16,
  parameter int LAG            = 1,
  parameter int SHIFT          = 15,
  parameter int CLEAR_ON_TLAST = 1
) (
  input  logic                 s00_axis_aclk,
  input  logic                 s00_axis_areset,
  conj_delay_demod_if.slave    s00_axis,
  conj_delay_demod_if.master   m00_axis,
  input  logic                 bypass,
  input  logic                 sat_clear,
  output logic                 sat_flag
);
  localparam int IW  = 2 * DATA_W;
  localparam int PW  = 2 * DATA_W;
  localparam int SW  = 2 * DATA_W + 2;
  localparam int ISB = IW / 8;
  localparam int OSB = (2 * OUT_W) / 8;

  localparam logic signed [SW-1:0] MAXV = SW'((longint'(1) <<< (OUT_W - 1)) - 1);
  localparam logic signed [SW-1:0] MINV = SW'(-(longint'(1) <<< (OUT_W - 1)));
  localparam logic signed [SW-1:0] RND  = (SHIFT > 0) ?
      SW'(longint'(1) <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : SW'(0);

  logic clk, rst;
  assign clk = s00_axis_aclk;
  assign rst = s00_axis_areset;

  logic en, acc;
  assign en              = ~m00_axis.tvalid | m00_axis.tready;
  assign s00_axis.tready = en;
  assign acc             = en & s00_axis.tvalid;

  logic [IW-1:0] hist [LAG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < int'(LAG); i++) hist[i] <= '0;
    end else if (acc) begin
      if ((CLEAR_ON_TLAST != 0) && s00_axis.tlast) begin
        for (int unsigned i = 0; i < int'(LAG); i++) hist[i] <= '0;
      end else begin
        hist[0] <= s00_axis.tdata;
        for (int unsigned i = 1; i < int'(LAG); i++) hist[i] <= hist[i-1];
      end
    end
  end

  // Stage 1: current sample a+jb, delayed sample c+jd
  logic                     v1, l1, by1;
  logic signed [DATA_W-1:0] a1, b1, c1, d1;
  logic [ISB-1:0]           st1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0; l1 <= 1'b0; by1 <= 1'b0; st1 <= '0;
      a1 <= '0; b1 <= '0; c1 <= '0; d1 <= '0;
    end else if (en) begin
      v1 <= s00_axis.tvalid;
      if (s00_axis.tvalid) begin
        a1  <= s00_axis.tdata[DATA_W-1:0];
        b1  <= s00_axis.tdata[IW-1:DATA_W];
        c1  <= hist[LAG-1][DATA_W-1:0];
        d1  <= hist[LAG-1][IW-1:DATA_W];
        l1  <= s00_axis.tlast;
        st1 <= s00_axis.tstrb;
        by1 <= bypass;
      end
    end
  end

  // Stage 2: full-precision partial products
  logic                     v2, l2, by2;
  logic signed [PW-1:0]     ac2, bd2, bc2, ad2;
  logic signed [DATA_W-1:0] a2, b2;
  logic [ISB-1:0]           st2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2 <= 1'b0; l2 <= 1'b0; by2 <= 1'b0; st2 <= '0;
      ac2 <= '0; bd2 <= '0; bc2 <= '0; ad2 <= '0; a2 <= '0; b2 <= '0;
    end else if (en) begin
      v2 <= v1;
      if (v1) begin
        ac2 <= PW'(a1) * PW'(c1);
        bd2 <= PW'(b1) * PW'(d1);
        bc2 <= PW'(b1) * PW'(c1);
        ad2 <= PW'(a1) * PW'(d1);
        a2  <= a1; b2 <= b1;
        l2  <= l1; st2 <= st1; by2 <= by1;
      end
    end
  end

  // Stage 3: sums registered before rounding so accept-to-output is three edges
  logic                     v3, l3, by3;
  logic signed [PW:0]       re3, im3;
  logic signed [DATA_W-1:0] a3, b3;
  logic [ISB-1:0]           st3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3 <= 1'b0; l3 <= 1'b0; by3 <= 1'b0; st3 <= '0;
      re3 <= '0; im3 <= '0; a3 <= '0; b3 <= '0;
    end else if (en) begin
      v3 <= v2;
      if (v2) begin
        re3 <= (PW+1)'(ac2) + (PW+1)'(bd2);
        im3 <= (PW+1)'(bc2) - (PW+1)'(ad2);
        a3  <= a2; b3 <= b2;
        l3  <= l2; st3 <= st2; by3 <= by2;
      end
    end
  end

  // Returns {clipped, value}
  function automatic logic [OUT_W:0] rnd_sat(input logic signed [PW:0] v);
    logic signed [SW-1:0] t;
    t = (SW'(v) + RND) >>> SHIFT;
    if (t > MAXV) return {1'b1, MAXV[OUT_W-1:0]};
    if (t < MINV) return {1'b1, MINV[OUT_W-1:0]};
    return {1'b0, t[OUT_W-1:0]};
  endfunction

  logic [OUT_W:0] re_rs, im_rs;
  logic           clip;

  always_comb begin
    re_rs = rnd_sat(re3);
    im_rs = rnd_sat(im3);
    clip  = re_rs[OUT_W] | im_rs[OUT_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m00_axis.tvalid <= 1'b0;
      m00_axis.tdata  <= '0;
      m00_axis.tlast  <= 1'b0;
      m00_axis.tstrb  <= '0;
    end else if (en) begin
      m00_axis.tvalid <= v3;
      if (v3) begin
        m00_axis.tdata <= by3 ? {OUT_W'(b3), OUT_W'(a3)}
                              : {im_rs[OUT_W-1:0], re_rs[OUT_W-1:0]};
        m00_axis.tlast <= l3;
        m00_axis.tstrb <= OSB'(st3);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          sat_flag <= 1'b0;
    else if (en && v3 && !by3 && clip) sat_flag <= 1'b1;
    else if (sat_clear)               sat_flag <= 1'b0;
  end
endmodule

// File: tb/tb_conj_delay_demod.sv
// Scoreboard bench: drivers push expected products into queues, monitors pop on each output beat.
module tb_conj_delay_demod;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic byp_a, sc_a, sf_a, byp_b, sc_b, sf_b;

  conj_delay_demod_if #(.W(32)) sa ();
  conj_delay_demod_if #(.W(32)) ma ();
  conj_delay_demod_if #(.W(32)) sb ();
  conj_delay_demod_if #(.W(32)) mb ();

  conj_delay_demod #(.DATA_W(16), .OUT_W(16), .LAG(1), .SHIFT(15), .CLEAR_ON_TLAST(1)) dut_a (
    .s00_axis_aclk(clk), .s00_axis_areset(rst), .s00_axis(sa), .m00_axis(ma),
    .bypass(byp_a), .sat_clear(sc_a), .sat_flag(sf_a));

  conj_delay_demod #(.DATA_W(16), .OUT_W(16), .LAG(4), .SHIFT(15), .CLEAR_ON_TLAST(0)) dut_b (
    .s00_axis_aclk(clk), .s00_axis_areset(rst), .s00_axis(sb), .m00_axis(mb),
    .bypass(byp_b), .sat_clear(sc_b), .sat_flag(sf_b));

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [3:0]  strb;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  bit lat_chk = 1'b0;
  bit rnd_ready = 1'b0;

  logic signed [15:0] ha_re, ha_im;
  logic signed [15:0] hb_re [4];
  logic signed [15:0] hb_im [4];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    ma.tready = rnd_ready ? ($urandom_range(0, 99) < 40) : 1'b1;
    mb.tready = 1'b1;
  end

  function automatic logic [15:0] clamp(input longint v);
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  function automatic logic [31:0] model(input logic signed [15:0] a, b, c, d);
    longint re, im;
    re = longint'(a) * longint'(c) + longint'(b) * longint'(d);
    im = longint'(b) * longint'(c) - longint'(a) * longint'(d);
    re = (re + 16384) >>> 15;
    im = (im + 16384) >>> 15;
    return {clamp(im), clamp(re)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      mismatched++;
    end
  endtask

  task automatic drive_a(input logic [31:0] d, input logic last, input logic byp,
                         input logic [3:0] strb, input bit hand, input logic [31:0] hexp);
    exp_t e;
    bit   acc;
    int   n;
    sa.tvalid = 1'b1; sa.tdata = d; sa.tlast = last; sa.tstrb = strb; byp_a = byp;
    acc = 1'b0; n = 0;
    while (!acc && n < 200) begin
      @(negedge clk); acc = sa.tready;
      @(posedge clk); #1; n++;
    end
    sa.tvalid = 1'b0;
    if (!acc) begin
      compared++; mismatched++;
      $display("FAIL accept_a: got no acceptance expected tready within 200 cycles");
    end else begin
      e.data = hand ? hexp : (byp ? d : model(d[15:0], d[31:16], ha_re, ha_im));
      e.last = last; e.strb = strb; e.acc = cyc; e.lat = lat_chk;
      qa.push_back(e);
      ha_re = d[15:0]; ha_im = d[31:16];
      if (last) begin ha_re = '0; ha_im = '0; end
    end
  endtask

  task automatic drive_b(input logic [31:0] d, input bit hand, input logic [31:0] hexp);
    exp_t e;
    bit   acc;
    int   n;
    sb.tvalid = 1'b1; sb.tdata = d; sb.tlast = 1'b0; sb.tstrb = 4'hF;
    acc = 1'b0; n = 0;
    while (!acc && n < 200) begin
      @(negedge clk); acc = sb.tready;
      @(posedge clk); #1; n++;
    end
    sb.tvalid = 1'b0;
    if (!acc) begin
      compared++; mismatched++;
      $display("FAIL accept_b: got no acceptance expected tready within 200 cycles");
    end else begin
      e.data = hand ? hexp : model(d[15:0], d[31:16], hb_re[3], hb_im[3]);
      e.last = 1'b0; e.strb = 4'hF; e.acc = cyc; e.lat = 1'b0;
      qb.push_back(e);
      for (int i = 3; i > 0; i--) begin hb_re[i] = hb_re[i-1]; hb_im[i] = hb_im[i-1]; end
      hb_re[0] = d[15:0]; hb_im[0] = d[31:16];
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qa.size() > 0 || qb.size() > 0) && n < 500) begin @(posedge clk); #1; n++; end
    if (qa.size() > 0 || qb.size() > 0) begin
      compared++; mismatched++;
      $display("FAIL drain: got %0d/%0d outputs pending expected 0", qa.size(), qb.size());
      qa.delete(); qb.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  logic [36:0] hold_a;
  bit          stalled_a = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stalled_a = 1'b0;
    end else begin
      if (stalled_a) begin
        compared++;
        if (!ma.tvalid || {ma.tdata, ma.tlast, ma.tstrb} !== hold_a) begin
          mismatched++;
          $display("FAIL stall_hold: got v=%0b %0h expected v=1 %0h", ma.tvalid,
                   {ma.tdata, ma.tlast, ma.tstrb}, hold_a);
        end
      end
      if (ma.tvalid && ma.tready) begin
        stalled_a = 1'b0;
        if (qa.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL extra_a: got output %0h expected none", ma.tdata);
        end else begin
          e = qa.pop_front();
          compared++;
          if (ma.tdata !== e.data || ma.tlast !== e.last || ma.tstrb !== e.strb) begin
            mismatched++;
            $display("FAIL out_a: got %0h last=%0b strb=%0h expected %0h last=%0b strb=%0h",
                     ma.tdata, ma.tlast, ma.tstrb, e.data, e.last, e.strb);
          end
          if (e.lat) begin
            compared++;
            if (cyc - e.acc != 3) begin
              mismatched++;
              $display("FAIL latency_a: got %0d expected 3", cyc - e.acc);
            end
          end
        end
      end else if (ma.tvalid) begin
        stalled_a = 1'b1;
        hold_a = {ma.tdata, ma.tlast, ma.tstrb};
      end else begin
        stalled_a = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && mb.tvalid && mb.tready) begin
      if (qb.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL extra_b: got output %0h expected none", mb.tdata);
      end else begin
        e = qb.pop_front();
        compared++;
        if (mb.tdata !== e.data) begin
          mismatched++;
          $display("FAIL out_b: got %0h expected %0h", mb.tdata, e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    rst = 1'b1;
    sa.tvalid = 1'b0; sa.tdata = '0; sa.tlast = 1'b0; sa.tstrb = '0;
    sb.tvalid = 1'b0; sb.tdata = '0; sb.tlast = 1'b0; sb.tstrb = '0;
    byp_a = 1'b0; byp_b = 1'b0; sc_a = 1'b0; sc_b = 1'b0;
    ha_re = '0; ha_im = '0;
    for (int i = 0; i < 4; i++) begin hb_re[i] = '0; hb_im[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid_a", ma.tvalid, 0);
    chk("rst_tdata_a", ma.tdata, 0);
    chk("rst_tlast_strb_a", {ma.tlast, ma.tstrb}, 0);
    chk("rst_sat_a", sf_a, 0);
    chk("rst_tvalid_b", mb.tvalid, 0);
    chk("rst_sat_b", sf_b, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic product and 3-cycle latency
    lat_chk = 1'b1;
    drive_a(32'h0000_4000, 1'b0, 1'b0, 4'hF, 1'b1, 32'h0000_0000);
    drive_a(32'h4000_0000, 1'b1, 1'b0, 4'hF, 1'b1, 32'h2000_0000);
    lat_chk = 1'b0;
    drain();
    chk("sat_idle", sf_a, 0);

    // Saturation and sticky flag
    drive_a(32'h8000_8000, 1'b0, 1'b0, 4'hF, 1'b1, 32'h0000_0000);
    drive_a(32'h8000_8000, 1'b1, 1'b0, 4'hF, 1'b1, 32'h0000_7FFF);
    drain();
    chk("sat_set", sf_a, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("sat_sticky", sf_a, 1);
    sc_a = 1'b1;
    @(posedge clk); #1;
    sc_a = 1'b0;
    chk("sat_cleared", sf_a, 0);

    // History flush on tlast
    for (int i = 0; i < 6; i++)
      drive_a(32'h0000_1000, (i == 3), 1'b0, 4'h3, 1'b1,
              (i == 0 || i == 4) ? 32'h0000_0000 : 32'h0000_0200);
    drive_a(32'hABCD_1234, 1'b0, 1'b1, 4'hF, 1'b1, 32'hABCD_1234);
    sa.tlast = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    drive_a(32'h0000_1000, 1'b0, 1'b0, 4'h5, 1'b0, 32'h0);
    drain();

    // LAG=4 ramp
    for (int n = 0; n < 8; n++) begin
      d = {16'(-(n + 1) * 512), 16'((n + 1) * 1024)};
      drive_b(d, (n < 4), 32'h0);
    end
    drain();

    // Random backpressure
    rnd_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      drive_a($urandom, ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
              4'($urandom), 1'b0, 32'h0);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    rnd_ready = 1'b0;
    drain();

    // Reset mid-burst
    for (int n = 0; n < 5; n++) drive_a(32'h0100_0200 + n, 1'b0, 1'b0, 4'hF, 1'b0, 32'h0);
    chk("pre_rst_tvalid", ma.tvalid, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_tvalid", ma.tvalid, 0);
    qa.delete();
    ha_re = '0; ha_im = '0;
    for (int i = 0; i < 4; i++) begin hb_re[i] = '0; hb_im[i] = '0; end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    drive_a(32'h0000_1000, 1'b0, 1'b0, 4'hF, 1'b1, 32'h0000_0000);
    drive_a(32'h0000_1000, 1'b0, 1'b0, 4'hF, 1'b1, 32'h0000_0200);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/conj_delay_demod.md
Name: conj_delay_demod

Overview:
- Parametrised successor of the single-lag conjugate-multiply FM discriminator: computes y[n] = x[n] · conj(x[n−LAG]) on an AXI-Stream IQ stream.
- Full-precision products with rounding, arithmetic shift and saturation to a selectable output width.
- 3-stage pipeline with full backpressure, optional history flush on packet boundary, sticky saturation flag and runtime bypass.
- Sits between the decimating front end and the CORDIC angle extractor.

Parameters:
- DATA_W, 16, bits per input component; s00 tdata = {imag, real}, two's complement.
- OUT_W, 16, bits per output component; m00 tdata = {imag, real}.
- LAG, 1, delay in accepted samples (1..64).
- SHIFT, 15, arithmetic right shift applied to full-precision sums (0..2·DATA_W).
- CLEAR_ON_TLAST, 1, 1 = zero history after a tlast sample is accepted.

Ports:
- s00_axis_aclk  in  1  sole clock
- s00_axis_areset  in  1  asynchronous active-high reset
- s00_axis_tvalid  in  1  input valid
- s00_axis_tready  out  1  input ready
- s00_axis_tdata  in  2·DATA_W  {imag, real}
- s00_axis_tlast  in  1  packet end
- s00_axis_tstrb  in  2·DATA_W/8  passed through
- m00_axis_tvalid  out  1  output valid
- m00_axis_tready  in  1  downstream ready
- m00_axis_tdata  out  2·OUT_W  {imag, real} of product
- m00_axis_tlast  out  1  delayed tlast
- m00_axis_tstrb  out  2·OUT_W/8  delayed tstrb (low bits, zero-extended)
- bypass  in  1  1 = output current sample unmodified (resized)
- sat_clear  in  1  clears sat_flag
- sat_flag  out  1  sticky: any component saturated since last clear/reset

Behaviour:
- Reset (async assert, sync release):
  - m00_axis_tvalid/tdata/tlast/tstrb = 0, sat_flag = 0.
  - All pipeline valids = 0, history registers = 0.
  - Reset mid-stream discards every in-flight sample.
- Handshake:
  - en = ~m00_axis_tvalid | m00_axis_tready; s00_axis_tready = en; all stages advance only when en.
  - Bubbles propagate as valid = 0.
  - m00_axis_tdata/tlast/tstrb hold stable while tvalid=1 and tready=0.
- Latency: a sample accepted at edge k appears on m00 at edge k+3 with no stall; throughput 1 sample/clock.
- Stage 1:
  - Register a+jb = current sample, c+jd = history[LAG−1], tlast, tstrb, bypass.
  - On acceptance the history shift register advances (history[0] ← sample).
  - If CLEAR_ON_TLAST and tlast is accepted, all history ← 0 at that edge, so the next packet's first LAG outputs are 0.
- Stage 2: four signed 2·DATA_W products ac, bd, bc, ad.
- Stage 3 arithmetic:
  - re = ac + bd, im = bc − ad, each 2·DATA_W+1 bits.
  - If SHIFT>0, add 2^(SHIFT−1) (round half up), then arithmetic shift right by SHIFT.
  - Saturate to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- Bypass: output = {a, b} sign-extended or truncated to OUT_W, without saturation; history still updates.
- Priming: the first LAG outputs after reset (or flush) multiply by 0 → output 0 (unless bypass).
- sat_flag:
  - Set when a stage-3 result clips and is written to the output register.
  - sat_clear and a set in the same cycle → set wins.
- Simultaneous events:
  - Acceptance and output consumption in the same cycle → both happen, no bubble.
  - tlast with tvalid=0 is ignored.

Test Plan:
- LAG=1, inputs (re=0x4000, im=0) then (re=0, im=0x4000) → outputs 0x0000_0000 then 0x2000_0000, each 3 clocks after acceptance.
- Two samples (−32768, −32768) → second output real saturates to 0x7FFF, imag 0, sat_flag=1; pulse sat_clear → 0.
- LAG=4, 8-sample ramp → first 4 outputs 0, output n = x[n]·conj(x[n−4]) checked against a bench reference model.
- CLEAR_ON_TLAST=1, tlast on sample 3 of a constant stream (0x1000, 0) → output 4 = 0; outputs 3 and 5 = 0x0000_0200.
- Random m00_axis_tready (≈40%), 1000 samples → no loss or duplication, data and tlast stable while stalled, ordering preserved.
- Assert reset mid-burst with 3 samples in flight → m00_axis_tvalid drops immediately; after release the first output uses zero history.
